id_stage: RTL

Instruction-decode stage of the 5-stage RV32I pipeline, between the fetch stage and the execute stage. It decodes the fetched instruction, drives the register-file read addresses and generates the immediate. It bypasses the same-cycle writeback value, detects load-use hazards, and captures all operands into the ID/EX pipeline register under valid/ready flow control.

---
 rtl/id_stage_if.sv | 29 ++
 rtl/id_stage.sv | 94 +++++++++
 2 files changed

// File: rtl/id_stage_if.sv
// id_stage_if: ID/EX pipeline register bus between decode (master) and execute (slave)
interface id_stage_if #(parameter int XLEN = 32);
  logic ex_ready;
  logic id_ex_valid;
  logic [XLEN-1:0] id_ex_pc;
  logic [XLEN-1:0] id_ex_rs1_val;
  logic [XLEN-1:0] id_ex_rs2_val;
  logic [XLEN-1:0] id_ex_imm;
  logic [4:0] id_ex_rs1;
  logic [4:0] id_ex_rs2;
  logic [4:0] id_ex_rd;
  logic [6:0] id_ex_opcode;
  logic [2:0] id_ex_funct3;
  logic id_ex_funct7b5;
  logic id_ex_regwrite;
  logic id_ex_illegal;
  modport master(
    input ex_ready,
    output id_ex_valid, id_ex_pc, id_ex_rs1_val, id_ex_rs2_val, id_ex_imm,
    output id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_opcode, id_ex_funct3,
    output id_ex_funct7b5, id_ex_regwrite, id_ex_illegal
  );
  modport slave(
    output ex_ready,
    input id_ex_valid, id_ex_pc, id_ex_rs1_val, id_ex_rs2_val, id_ex_imm,
    input id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_opcode, id_ex_funct3,
    input id_ex_funct7b5, id_ex_regwrite, id_ex_illegal
  );
endinterface

// File: rtl/id_stage.sv
// id_stage: RV32I decode with WB bypass, load-use stall and ID/EX register
module id_stage #(parameter int XLEN = 32) (
  input  logic clk,
  input  logic reset,
  input  logic if_valid,
  input  logic [31:0] if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic id_ready,
  input  logic flush,
  output logic [4:0] rf_addr_a,
  output logic [4:0] rf_addr_b,
  input  logic [XLEN-1:0] rf_data_a,
  input  logic [XLEN-1:0] rf_data_b,
  input  logic wb_regwrite,
  input  logic [4:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic ex_load,
  input  logic [4:0] ex_rd,
  id_stage_if.master ex
);
  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  logic is_r, is_i, is_ld, is_jalr, is_s, is_b, is_lui, is_auipc, is_jal, is_sys;
  logic use_rs1, use_rs2, writes, legal, hazard;
  logic [XLEN-1:0] imm, rs1_val, rs2_val;
  assign opcode = if_instr[6:0];
  assign rs1 = if_instr[19:15];
  assign rs2 = if_instr[24:20];
  assign rd = if_instr[11:7];
  assign rf_addr_a = rs1;
  assign rf_addr_b = rs2;
  always_comb begin
    is_r = opcode == 7'b0110011;
    is_i = opcode == 7'b0010011;
    is_ld = opcode == 7'b0000011;
    is_jalr = opcode == 7'b1100111;
    is_s = opcode == 7'b0100011;
    is_b = opcode == 7'b1100011;
    is_lui = opcode == 7'b0110111;
    is_auipc = opcode == 7'b0010111;
    is_jal = opcode == 7'b1101111;
    is_sys = opcode == 7'b1110011 || opcode == 7'b0001111;
    use_rs1 = is_r | is_i | is_ld | is_jalr | is_s | is_b;
    use_rs2 = is_r | is_s | is_b;
    writes = is_r | is_i | is_ld | is_jalr | is_lui | is_auipc | is_jal;
    legal = writes | is_s | is_b | is_sys;
    imm = (is_i | is_ld | is_jalr) ? {{20{if_instr[31]}}, if_instr[31:20]} :
          is_s ? {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]} :
          is_b ? {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0} :
          (is_lui | is_auipc) ? {if_instr[31:12], 12'b0} :
          is_jal ? {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0} :
          '0;
    rs1_val = rs1 == 5'd0 ? '0 : (wb_regwrite && wb_rd == rs1) ? wb_data : rf_data_a;
    rs2_val = rs2 == 5'd0 ? '0 : (wb_regwrite && wb_rd == rs2) ? wb_data : rf_data_b;
    hazard = if_valid & ex_load & (ex_rd != 5'd0) &
             ((use_rs1 & (ex_rd == rs1)) | (use_rs2 & (ex_rd == rs2)));
  end
  assign id_ready = ex.ex_ready & ~hazard;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex.id_ex_valid <= 1'b0;
      ex.id_ex_pc <= '0;
      ex.id_ex_rs1_val <= '0;
      ex.id_ex_rs2_val <= '0;
      ex.id_ex_imm <= '0;
      ex.id_ex_rs1 <= '0;
      ex.id_ex_rs2 <= '0;
      ex.id_ex_rd <= '0;
      ex.id_ex_opcode <= '0;
      ex.id_ex_funct3 <= '0;
      ex.id_ex_funct7b5 <= 1'b0;
      ex.id_ex_regwrite <= 1'b0;
      ex.id_ex_illegal <= 1'b0;
    end else if (flush || (ex.ex_ready && hazard)) begin
      ex.id_ex_valid <= 1'b0;
      ex.id_ex_regwrite <= 1'b0;
      ex.id_ex_illegal <= 1'b0;
    end else if (ex.ex_ready) begin
      ex.id_ex_valid <= if_valid;
      ex.id_ex_pc <= if_pc;
      ex.id_ex_rs1_val <= rs1_val;
      ex.id_ex_rs2_val <= rs2_val;
      ex.id_ex_imm <= imm;
      ex.id_ex_rs1 <= rs1;
      ex.id_ex_rs2 <= rs2;
      ex.id_ex_rd <= rd;
      ex.id_ex_opcode <= opcode;
      ex.id_ex_funct3 <= if_instr[14:12];
      ex.id_ex_funct7b5 <= if_instr[30];
      ex.id_ex_regwrite <= if_valid & writes & (rd != 5'd0);
      ex.id_ex_illegal <= if_valid & ~legal;
    end
  end
endmodule
